// File: rtl/mp_add_sequencer_if.sv
// Operand stream, adder hookup and result stream of the multi-precision add sequencer.
// MP_ADD_OVF_EN adds the signed-overflow flag out_ovf.
interface mp_add_sequencer_if #(parameter int IDX_W = 8);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             in_first;
    logic             in_last;
    logic             in_sub;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic             add_carry_i;
    logic [31:0]      add_sum;
    logic             add_carry_o;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_carry;
    logic             err_restart;
`ifdef MP_ADD_OVF_EN
    logic             out_ovf;
`endif

    modport slave (
        input  in_valid, in_a, in_b, in_first, in_last, in_sub,
        input  add_sum, add_carry_o, out_ready,
        output in_ready, add_a, add_b, add_carry_i,
        output out_valid, out_sum, out_idx, out_last, out_carry,
`ifdef MP_ADD_OVF_EN
        output out_ovf,
`endif
        output err_restart
    );

    modport master (
        output in_valid, in_a, in_b, in_first, in_last, in_sub,
        output add_sum, add_carry_o, out_ready,
        input  in_ready, add_a, add_b, add_carry_i,
        input  out_valid, out_sum, out_idx, out_last, out_carry,
`ifdef MP_ADD_OVF_EN
        input  out_ovf,
`endif
        input  err_restart
    );
endinterface

// File: rtl/mp_add_sequencer.sv
// Word-serial add/subtract sequencer around an external 32-bit adder.
// MP_ADD_OVF_EN enables the out_ovf signed-overflow flag on the last word.
module mp_add_sequencer #(
    parameter int IDX_W = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    mp_add_sequencer_if.slave   bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic             carry_q;
    logic             op_sub_q;
    logic [IDX_W-1:0] idx_q;

    logic             accept;
    logic             eff_first;
    logic             sub;
    logic [31:0]      add_b_w;
    logic [IDX_W-1:0] base_idx;

    assign bus.in_ready = ~bus.out_valid | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;

    // Outside an operation every beat opens a new one.
    assign eff_first = bus.in_first | (state == IDLE);
    assign sub       = eff_first ? bus.in_sub : op_sub_q;
    assign add_b_w   = sub ? ~bus.in_b : bus.in_b;
    assign base_idx  = eff_first ? '0 : idx_q;

    assign bus.add_a       = bus.in_a;
    assign bus.add_b       = add_b_w;
    assign bus.add_carry_i = eff_first ? sub : carry_q;

`ifdef MP_ADD_OVF_EN
    logic ovf_w;
    assign ovf_w = (bus.in_a[31] == add_b_w[31]) &
                   (bus.add_sum[31] != bus.in_a[31]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            carry_q         <= 1'b0;
            op_sub_q        <= 1'b0;
            idx_q           <= '0;
            bus.out_valid   <= 1'b0;
            bus.out_sum     <= '0;
            bus.out_idx     <= '0;
            bus.out_last    <= 1'b0;
            bus.out_carry   <= 1'b0;
            bus.err_restart <= 1'b0;
`ifdef MP_ADD_OVF_EN
            bus.out_ovf     <= 1'b0;
`endif
        end else begin
            bus.err_restart <= accept & bus.in_first & (state == RUN);
            if (accept) begin
                bus.out_valid <= 1'b1;
                bus.out_sum   <= bus.add_sum;
                bus.out_idx   <= base_idx;
                bus.out_last  <= bus.in_last;
                // Subtract reports borrow, the inverse of the adder carry.
                bus.out_carry <= bus.in_last & (bus.add_carry_o ^ sub);
`ifdef MP_ADD_OVF_EN
                bus.out_ovf   <= bus.in_last & ovf_w;
`endif
                carry_q       <= bus.add_carry_o;
                op_sub_q      <= sub;
                idx_q         <= base_idx + 1'b1;
                state         <= bus.in_last ? IDLE : RUN;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mp_add_sequencer.sv
// Bench for mp_add_sequencer: directed vector table, corner sequences and
// randomized multi-word operations checked against a big-integer model.
module tb_mp_add_sequencer;
    logic clk;
    logic rst_n;

    mp_add_sequencer_if #(.IDX_W(8)) ifc ();

    mp_add_sequencer #(.IDX_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    // Behavioural 32-bit ripple adder downstream of the sequencer.
    assign {ifc.add_carry_o, ifc.add_sum} =
        {1'b0, ifc.add_a} + {1'b0, ifc.add_b} + {32'd0, ifc.add_carry_i};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic [7:0]  idx;
        logic        last;
        logic        carry;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        first;
        logic        last;
        logic        sub;
        logic        cin;
        exp_t        e;
    } vec_t;

    exp_t        exp_q[$];
    int          total;
    int          passed;
    int          popped;
    logic [31:0] op_a[4];
    logic [31:0] op_b[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (rst_n && ifc.out_valid && ifc.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", ifc.out_sum, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                popped++;
                chk("out_sum", ifc.out_sum, e.sum);
                chk("out_idx", {24'd0, ifc.out_idx}, {24'd0, e.idx});
                chk("out_last", {31'd0, ifc.out_last}, {31'd0, e.last});
                chk("out_carry", {31'd0, ifc.out_carry}, {31'd0, e.carry});
`ifdef MP_ADD_OVF_EN
                chk("out_ovf", {31'd0, ifc.out_ovf}, {31'd0, e.ovf});
`endif
            end
        end
    end

    // Whole-operation reference: treat the words as one wide integer.
    task automatic push_op(input int n, input logic sub);
        logic [128:0] wa, wb, r;
        logic         c, sa, sb, sr, ov;
        exp_t         e;
        wa = '0;
        wb = '0;
        for (int i = 0; i < n; i++) begin
            wa[32*i +: 32] = op_a[i];
            wb[32*i +: 32] = op_b[i];
        end
        r  = sub ? wa - wb : wa + wb;
        c  = sub ? (wa < wb) : r[32*n];
        sa = wa[32*n-1];
        sb = wb[32*n-1];
        sr = r[32*n-1];
        ov = sub ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
        for (int i = 0; i < n; i++) begin
            e.sum   = r[32*i +: 32];
            e.idx   = 8'(i);
            e.last  = (i == n - 1);
            e.carry = e.last ? c : 1'b0;
            e.ovf   = e.last ? ov : 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic set_beat(input logic [31:0] a, input logic [31:0] b,
                            input logic f, input logic l, input logic s);
        ifc.in_a     = a;
        ifc.in_b     = b;
        ifc.in_first = f;
        ifc.in_last  = l;
        ifc.in_sub   = s;
        ifc.in_valid = 1'b1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic f, input logic l, input logic s,
                        input bit rnd);
        bit done;
        done = 0;
        set_beat(a, b, f, l, s);
        for (int k = 0; k < 100 && !done; k++) begin
            if (rnd) ifc.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (ifc.in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        ifc.in_valid = 1'b0;
    endtask

    task automatic drain();
        ifc.out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        chk("drain_left", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[9];
    int   base;
    logic [31:0] held;

    initial begin
        total  = 0;
        passed = 0;
        popped = 0;
        vecs[0] = '{32'hFFFF_FFFF, 32'h1, 1, 1, 0, 0, '{32'h0, 0, 1, 1, 0}};
        vecs[1] = '{32'hFFFF_FFFF, 32'h1, 1, 0, 0, 0, '{32'h0, 0, 0, 0, 0}};
        vecs[2] = '{32'h1, 32'h0, 0, 1, 0, 1, '{32'h2, 1, 1, 0, 0}};
        vecs[3] = '{32'h0, 32'h1, 1, 0, 1, 1, '{32'hFFFF_FFFF, 0, 0, 0, 0}};
        vecs[4] = '{32'h0, 32'h0, 0, 1, 0, 0, '{32'hFFFF_FFFF, 1, 1, 1, 0}};
        vecs[5] = '{32'h5, 32'h3, 0, 1, 1, 1, '{32'h2, 0, 1, 0, 0}};
        vecs[6] = '{32'h7FFF_FFFF, 32'h1, 1, 1, 0, 0,
                    '{32'h8000_0000, 0, 1, 0, 1}};
        vecs[7] = '{32'h8000_0000, 32'h1, 1, 1, 1, 1,
                    '{32'h7FFF_FFFF, 0, 1, 0, 1}};
        vecs[8] = '{32'h3, 32'h5, 1, 1, 1, 1, '{32'hFFFF_FFFE, 0, 1, 1, 0}};

        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        set_beat('0, '0, 0, 0, 0);
        ifc.in_valid  = 1'b0;
        #12;
        chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rst_out_sum", ifc.out_sum, 32'd0);
        chk("rst_err_restart", {31'd0, ifc.err_restart}, 32'd0);
        chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            set_beat(vecs[i].a, vecs[i].b, vecs[i].first,
                     vecs[i].last, vecs[i].sub);
            exp_q.push_back(vecs[i].e);
            @(negedge clk);
            chk($sformatf("vec%0d_carry_i", i),
                {31'd0, ifc.add_carry_i}, {31'd0, vecs[i].cin});
            @(posedge clk);
            #1;
        end
        ifc.in_valid = 1'b0;
        drain();

        // Backpressure: first word stalls the stream for three cycles.
        for (int i = 0; i < 4; i++) begin
            op_a[i] = $urandom;
            op_b[i] = $urandom;
        end
        push_op(4, 1'b0);
        base = popped;
        ifc.out_ready = 1'b0;
        send(op_a[0], op_b[0], 1, 0, 0, 0);
        held = ifc.out_sum;
        set_beat(op_a[1], op_b[1], 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, ifc.in_ready}, 32'd0);
            chk("bp_out_sum_held", ifc.out_sum, held);
            @(posedge clk);
            #1;
        end
        ifc.out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            set_beat(op_a[i], op_b[i], 0, i == 3, 0);
            @(negedge clk);
            chk("bp_full_rate", {31'd0, ifc.in_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        ifc.in_valid = 1'b0;
        drain();
        chk("bp_word_count", popped - base, 32'd4);

        // Restart inside RUN: carry from the first beat must not leak.
        exp_q.push_back('{32'h0, 0, 0, 0, 0});
        send(32'hFFFF_FFFF, 32'h1, 1, 0, 0, 0);
        chk("rs_no_err_yet", {31'd0, ifc.err_restart}, 32'd0);
        exp_q.push_back('{32'h5, 0, 1, 0, 0});
        send(32'h2, 32'h3, 1, 1, 0, 0);
        chk("rs_err_pulse", {31'd0, ifc.err_restart}, 32'd1);
        @(posedge clk);
        #1;
        chk("rs_err_single", {31'd0, ifc.err_restart}, 32'd0);
        drain();

        // Reset mid-operation discards the pending word and chain.
        ifc.out_ready = 1'b0;
        send(32'hFFFF_FFFF, 32'h1, 1, 0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("mr_out_sum", ifc.out_sum, 32'd0);
        chk("mr_out_idx", {24'd0, ifc.out_idx}, 32'd0);
        chk("mr_out_last", {31'd0, ifc.out_last}, 32'd0);
        chk("mr_out_carry", {31'd0, ifc.out_carry}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ifc.out_ready = 1'b1;
        exp_q.push_back('{32'h5, 0, 1, 0, 0});
        send(32'h2, 32'h3, 0, 1, 0, 0);
        drain();

        for (int op = 0; op < 40; op++) begin
            int  n;
            logic s;
            n = $urandom_range(1, 4);
            s = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                op_a[i] = $urandom;
                op_b[i] = $urandom;
                if ($urandom_range(0, 7) == 0) op_b[i] = op_a[i];
            end
            push_op(n, s);
            for (int i = 0; i < n; i++) begin
                send(op_a[i], op_b[i], i == 0, i == n - 1,
                     (i == 0) ? s : 1'($urandom_range(0, 1)), 1);
                if ($urandom_range(0, 3) == 0) begin
                    ifc.out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
